// File: rtl/display_scan_ctrl.sv
// Eight-digit multiplexed 7-segment scan controller with dead-time gaps and
// a double-buffered display value that only updates on frame boundaries.
module display_scan_ctrl #(
    parameter int unsigned ON_CYC  = 1000,
    parameter int unsigned GAP_CYC = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        wr_valid,
    input  logic [31:0] wr_data,
    output logic        wr_ready,
    input  logic [7:0]  digit_en,
    output logic [6:0]  seg,
    output logic [7:0]  an,
    output logic [2:0]  digit_sel,
    output logic        frame_done
);

    localparam int unsigned MAX_CYC = (ON_CYC > GAP_CYC) ? ON_CYC : GAP_CYC;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    typedef enum logic [1:0] {
        ST_OFF = 2'd0,
        ST_ON  = 2'd1,
        ST_GAP = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         digit_sel_q, digit_sel_d;
    logic [31:0]        disp_q, disp_d;
    logic [31:0]        shadow_q, shadow_d;
    logic               pending_q, pending_d;
    logic               frame_done_q, frame_done_d;
    logic [3:0]         nib;

    // Active-low 7-segment pattern, bit order g..a.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_OFF;
            cnt_q        <= '0;
            digit_sel_q  <= 3'd0;
            disp_q       <= 32'd0;
            shadow_q     <= 32'd0;
            pending_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            digit_sel_q  <= digit_sel_d;
            disp_q       <= disp_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Scan sequencing; disabling always wins over slot timing.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        digit_sel_d  = digit_sel_q;
        disp_d       = disp_q;
        shadow_d     = shadow_q;
        pending_d    = pending_q;
        frame_done_d = 1'b0;

        unique case (state_q)
            ST_OFF: begin
                cnt_d       = '0;
                digit_sel_d = 3'd0;
                if (pending_q) begin
                    disp_d    = shadow_q;
                    pending_d = 1'b0;
                end
                if (enable) begin
                    state_d = ST_ON;
                end
            end
            ST_ON: begin
                if (!enable) begin
                    state_d     = ST_OFF;
                    cnt_d       = '0;
                    digit_sel_d = 3'd0;
                end else if (cnt_q == CNT_W'(ON_CYC - 1)) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (!enable) begin
                    state_d     = ST_OFF;
                    cnt_d       = '0;
                    digit_sel_d = 3'd0;
                end else if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
                    state_d     = ST_ON;
                    cnt_d       = '0;
                    digit_sel_d = digit_sel_q + 3'd1;
                    // Frame boundary: the only point a scanning display may change value.
                    if (digit_sel_q == 3'd7) begin
                        frame_done_d = 1'b1;
                        if (pending_q) begin
                            disp_d    = shadow_q;
                            pending_d = 1'b0;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d     = ST_OFF;
                cnt_d       = '0;
                digit_sel_d = 3'd0;
            end
        endcase

        if (wr_valid && !pending_q) begin
            shadow_d  = wr_data;
            pending_d = 1'b1;
        end
    end

    assign nib = disp_q[{digit_sel_q, 2'b00} +: 4];

    // Drive decode; the digit mask acts within the current slot.
    always_comb begin
        an  = 8'hFF;
        seg = 7'h7F;
        if (state_q == ST_ON && digit_en[digit_sel_q]) begin
            an[digit_sel_q] = 1'b0;
            seg             = hex_to_seg(nib);
        end
    end

    assign wr_ready   = ~pending_q;
    assign digit_sel  = digit_sel_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Randomized bench for display_scan_ctrl against a frame-time reference model.
module tb_display_scan_ctrl;

    localparam int ON    = 4;
    localparam int GAP   = 2;
    localparam int SLOT  = ON + GAP;
    localparam int FRAME = 8 * SLOT;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        wr_valid;
    logic [31:0] wr_data;
    logic        wr_ready;
    logic [7:0]  digit_en;
    logic [6:0]  seg;
    logic [7:0]  an;
    logic [2:0]  digit_sel;
    logic        frame_done;

    int n_checks = 0;
    int n_errors = 0;

    logic [6:0] hex_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference model: scanning flag plus position within the 48-cycle frame.
    bit          m_scan;
    int          m_t;
    logic [31:0] m_disp, m_shadow;
    bit          m_pend, m_fd;

    display_scan_ctrl #(.ON_CYC(ON), .GAP_CYC(GAP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .digit_en   (digit_en),
        .seg        (seg),
        .an         (an),
        .digit_sel  (digit_sel),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_scan = 0; m_t = 0; m_disp = 0; m_shadow = 0; m_pend = 0; m_fd = 0;
    endtask

    task automatic model_step();
        bit commit, acc;
        if (!rst_n) begin
            model_reset();
            return;
        end
        acc    = wr_valid && !m_pend;
        commit = !m_scan && m_pend;
        m_fd   = 0;
        if (!enable) begin
            m_scan = 0; m_t = 0;
        end else if (!m_scan) begin
            m_scan = 1; m_t = 0;
        end else if (m_t == FRAME - 1) begin
            m_t = 0; m_fd = 1;
            if (m_pend) commit = 1;
        end else begin
            m_t++;
        end
        if (commit) begin m_disp = m_shadow; m_pend = 0; end
        if (acc)    begin m_shadow = wr_data; m_pend = 1; end
    endtask

    function automatic bit model_lit();
        return m_scan && (m_t % SLOT) < ON;
    endfunction

    function automatic int model_digit();
        return m_scan ? m_t / SLOT : 0;
    endfunction

    task automatic check_outs();
        int         d;
        logic [7:0] e_an;
        logic [6:0] e_seg;
        logic [31:0] sh;
        d     = model_digit();
        e_an  = 8'hFF;
        e_seg = 7'h7F;
        if (model_lit() && digit_en[d]) begin
            e_an  = ~(8'h01 << d);
            sh    = m_disp >> (4 * d);
            e_seg = hex_tbl[sh[3:0]];
        end
        chk("an", 32'(an), 32'(e_an));
        chk("seg", 32'(seg), 32'(e_seg));
        chk("digit_sel", 32'(digit_sel), 32'(d));
        chk("wr_ready", 32'(wr_ready), 32'(!m_pend));
        chk("frame_done", 32'(frame_done), 32'(m_fd));
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check_outs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic write(input logic [31:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        step();
        wr_valid = 1'b0;
    endtask

    initial begin
        bit found;
        rst_n = 1'b0; enable = 1'b0; wr_valid = 1'b0; wr_data = '0; digit_en = 8'hFF;
        model_reset();
        #12;
        check_outs();
        @(negedge clk);
        rst_n = 1'b1;

        // Write while off: value committed within two cycles, anodes stay dark.
        write(32'h7654_3210);
        run(3);

        // Full scan of 0..7 over two frames.
        enable = 1'b1;
        run(2 * FRAME + 4);

        // Mid-frame write is held until the boundary; a second write is ignored.
        run(10);
        write(32'hFFFF_FFFF);
        run(5);
        write(32'h1234_5678);
        run(FRAME + 10);

        // Masked digits keep their slots.
        digit_en = 8'b0000_0101;
        run(FRAME + 6);
        digit_en = 8'hFF;

        // Drop enable during digit 5's ON time, then restart from digit 0.
        found = 0;
        for (int i = 0; i < FRAME && !found; i++) begin
            if (model_digit() == 5 && model_lit()) found = 1;
            else step();
        end
        chk("reach_digit5", 32'(found), 32'd1);
        enable = 1'b0;
        run(3);
        enable = 1'b1;
        run(20);

        // Randomized traffic including mid-slot mask changes.
        for (int i = 0; i < 800; i++) begin
            enable   = ($urandom_range(0, 59) != 0);
            wr_valid = ($urandom_range(0, 7) == 0);
            wr_data  = $urandom;
            step();
            if ($urandom_range(0, 9) == 0) begin
                digit_en = 8'($urandom);
                #1;
                check_outs();
            end
        end
        wr_valid = 1'b0;
        digit_en = 8'hFF;
        enable   = 1'b1;

        // Asynchronous reset in a gap with a write pending.
        run(3);
        if (!m_pend) write(32'hABCD_EF01);
        found = 0;
        for (int i = 0; i < FRAME && !found; i++) begin
            if (m_scan && !model_lit() && m_pend) found = 1;
            else step();
        end
        chk("reach_gap_pending", 32'(found), 32'd1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outs();
        run(2);
        rst_n  = 1'b1;
        enable = 1'b0;
        run(4);
        enable = 1'b1;
        run(FRAME + 4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
